// File: rtl/alu_cond_stage.sv
// Condition/flag stage behind the ALU: holds NZCV, evaluates the ARM condition field,
// gates the write enables and registers them with the result toward writeback.
module alu_cond_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [3:0]        cond_i,
    input  logic [1:0]        flag_write_i,
    input  logic [3:0]        alu_flags_i,
    input  logic              reg_write_i,
    input  logic              mem_write_i,
    input  logic              pc_src_i,
    input  logic [DATA_W-1:0] result_i,
    output logic              valid_o,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              pc_src_o,
    output logic              cond_ex_o,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o,
    output logic [CNT_W-1:0]  exec_cnt_o,
    output logic [CNT_W-1:0]  squash_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_q,     valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_write_q, mem_write_d;
    logic              pc_src_q,    pc_src_d;
    logic              cond_ex_q,   cond_ex_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic [3:0]        flags_q,     flags_d;
    logic [CNT_W-1:0]  exec_cnt_q,  exec_cnt_d;
    logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex_c;
    logic pass_c;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition evaluated against the flag register before this instruction's own update
    always_comb begin
        cond_ex_c = 1'b1;
        case (cond_i)
            4'h0: cond_ex_c = flag_z;
            4'h1: cond_ex_c = ~flag_z;
            4'h2: cond_ex_c = flag_c;
            4'h3: cond_ex_c = ~flag_c;
            4'h4: cond_ex_c = flag_n;
            4'h5: cond_ex_c = ~flag_n;
            4'h6: cond_ex_c = flag_v;
            4'h7: cond_ex_c = ~flag_v;
            4'h8: cond_ex_c = flag_c & ~flag_z;
            4'h9: cond_ex_c = ~flag_c | flag_z;
            4'hA: cond_ex_c = (flag_n == flag_v);
            4'hB: cond_ex_c = (flag_n != flag_v);
            4'hC: cond_ex_c = ~flag_z & (flag_n == flag_v);
            4'hD: cond_ex_c = flag_z | (flag_n != flag_v);
            default: cond_ex_c = 1'b1;
        endcase
    end

    assign pass_c = valid_i & cond_ex_c;

    always_comb begin
        valid_d      = valid_i;
        cond_ex_d    = pass_c;
        reg_write_d  = pass_c & reg_write_i;
        mem_write_d  = pass_c & mem_write_i;
        pc_src_d     = pass_c & pc_src_i;
        result_d     = result_q;
        flags_d      = flags_q;
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;

        if (valid_i) begin
            result_d = result_i;
        end
        if (pass_c) begin
            if (flag_write_i[1]) flags_d[3:2] = alu_flags_i[3:2];
            if (flag_write_i[0]) flags_d[1:0] = alu_flags_i[1:0];
            if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (valid_i && !cond_ex_c && squash_cnt_q != CNT_MAX) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            cond_ex_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_src_q     <= 1'b0;
            result_q     <= '0;
            flags_q      <= 4'b0000;
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            cond_ex_q    <= cond_ex_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            pc_src_q     <= pc_src_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign cond_ex_o    = cond_ex_q;
    assign reg_write_o  = reg_write_q;
    assign mem_write_o  = mem_write_q;
    assign pc_src_o     = pc_src_q;
    assign result_o     = result_q;
    assign flags_o      = flags_q;
    assign exec_cnt_o   = exec_cnt_q;
    assign squash_cnt_o = squash_cnt_q;

endmodule

// File: tb/tb_alu_cond_stage.sv
// Directed bench for alu_cond_stage; a second instance with CNT_W=4 exercises saturation.
module tb_alu_cond_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [3:0]  cond_i;
    logic [1:0]  flag_write_i;
    logic [3:0]  alu_flags_i;
    logic        reg_write_i, mem_write_i, pc_src_i;
    logic [31:0] result_i;

    logic        valid_o, reg_write_o, mem_write_o, pc_src_o, cond_ex_o;
    logic [31:0] result_o;
    logic [3:0]  flags_o;
    logic [15:0] exec_cnt_o, squash_cnt_o;

    logic        s_valid_o, s_reg_write_o, s_mem_write_o, s_pc_src_o, s_cond_ex_o;
    logic [31:0] s_result_o;
    logic [3:0]  s_flags_o;
    logic [3:0]  s_exec_cnt_o, s_squash_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cond_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .cond_i(cond_i),
        .flag_write_i(flag_write_i), .alu_flags_i(alu_flags_i),
        .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
        .result_i(result_i), .valid_o(valid_o), .reg_write_o(reg_write_o),
        .mem_write_o(mem_write_o), .pc_src_o(pc_src_o), .cond_ex_o(cond_ex_o),
        .result_o(result_o), .flags_o(flags_o), .exec_cnt_o(exec_cnt_o),
        .squash_cnt_o(squash_cnt_o)
    );

    alu_cond_stage #(.DATA_W(32), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .valid_i(valid_i), .cond_i(cond_i),
        .flag_write_i(flag_write_i), .alu_flags_i(alu_flags_i),
        .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
        .result_i(result_i), .valid_o(s_valid_o), .reg_write_o(s_reg_write_o),
        .mem_write_o(s_mem_write_o), .pc_src_o(s_pc_src_o), .cond_ex_o(s_cond_ex_o),
        .result_o(s_result_o), .flags_o(s_flags_o), .exec_cnt_o(s_exec_cnt_o),
        .squash_cnt_o(s_squash_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] fl, input logic rw, input logic mw,
                         input logic pc, input logic [31:0] res);
        valid_i = v; cond_i = c; flag_write_i = fw; alu_flags_i = fl;
        reg_write_i = rw; mem_write_i = mw; pc_src_i = pc; result_i = res;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        // 1: reset held two cycles
        step(); step();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_rw", 32'(reg_write_o), 32'd0);
        chk("rst_mw", 32'(mem_write_o), 32'd0);
        chk("rst_pc", 32'(pc_src_o), 32'd0);
        chk("rst_condex", 32'(cond_ex_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_flags", 32'(flags_o), 32'd0);
        chk("rst_exec", 32'(exec_cnt_o), 32'd0);
        chk("rst_squash", 32'(squash_cnt_o), 32'd0);

        // 2: AL sets Z, then EQ passes in the next cycle
        reset = 1'b0;
        drive(1'b1, 4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 32'h0000_0011);
        step();
        chk("t2_flags", 32'(flags_o), 32'h4);
        chk("t2_condex0", 32'(cond_ex_o), 32'd1);
        chk("t2_rw0", 32'(reg_write_o), 32'd0);
        chk("t2_result0", result_o, 32'h11);
        drive(1'b1, 4'h0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0000_0022);
        step();
        chk("t2_rw", 32'(reg_write_o), 32'd1);
        chk("t2_pc", 32'(pc_src_o), 32'd1);
        chk("t2_exec", 32'(exec_cnt_o), 32'd2);
        chk("t2_result1", result_o, 32'h22);

        // 3: NE fails with Z=1, its flag write is suppressed
        drive(1'b1, 4'h1, 2'b11, 4'b1000, 1'b1, 1'b1, 1'b0, 32'h0000_0033);
        step();
        chk("t3_rw", 32'(reg_write_o), 32'd0);
        chk("t3_mw", 32'(mem_write_o), 32'd0);
        chk("t3_condex", 32'(cond_ex_o), 32'd0);
        chk("t3_valid", 32'(valid_o), 32'd1);
        chk("t3_flags", 32'(flags_o), 32'h4);
        chk("t3_squash", 32'(squash_cnt_o), 32'd1);
        chk("t3_exec", 32'(exec_cnt_o), 32'd2);
        chk("t3_result", result_o, 32'h33);

        // Bubble: nothing changes, enables drop, result holds
        drive(1'b0, 4'h1, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 32'h0000_0044);
        step();
        chk("bub_valid", 32'(valid_o), 32'd0);
        chk("bub_rw", 32'(reg_write_o), 32'd0);
        chk("bub_flags", 32'(flags_o), 32'h4);
        chk("bub_result", result_o, 32'h33);
        chk("bub_squash", 32'(squash_cnt_o), 32'd1);

        // 4: flags=0011, partial N,Z update -> 1111, then GE passes, LT fails
        drive(1'b1, 4'hE, 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t4_flags0", 32'(flags_o), 32'h3);
        drive(1'b1, 4'hE, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t4_flags1", 32'(flags_o), 32'hF);
        drive(1'b1, 4'hA, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t4_ge", 32'(cond_ex_o), 32'd1);
        drive(1'b1, 4'hB, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t4_lt", 32'(cond_ex_o), 32'd0);
        drive(1'b1, 4'hC, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t4_gt", 32'(cond_ex_o), 32'd0);
        drive(1'b1, 4'h9, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("t4_ls", 32'(cond_ex_o), 32'd1);
        chk("t4_ls_mw", 32'(mem_write_o), 32'd1);
        chk("t4_exec", 32'(exec_cnt_o), 32'd6);
        chk("t4_squash", 32'(squash_cnt_o), 32'd3);

        // 5: fresh reset, 17 AL instructions saturate the 4-bit counters at 15
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 4'hE, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 32'(i));
            step();
        end
        chk("t5_small_exec", 32'(s_exec_cnt_o), 32'd15);
        chk("t5_small_squash", 32'(s_squash_cnt_o), 32'd0);
        chk("t5_exec", 32'(exec_cnt_o), 32'd17);
        chk("t5_flags", 32'(flags_o), 32'hA);
        chk("t5_result", result_o, 32'd16);

        // 6: reset wins over a valid, writing instruction
        reset = 1'b1;
        drive(1'b1, 4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
        step();
        chk("t6_valid", 32'(valid_o), 32'd0);
        chk("t6_rw", 32'(reg_write_o), 32'd0);
        chk("t6_flags", 32'(flags_o), 32'd0);
        chk("t6_exec", 32'(exec_cnt_o), 32'd0);
        chk("t6_squash", 32'(squash_cnt_o), 32'd0);
        chk("t6_result", result_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
